// File: rtl/ovi_sb_pkg.sv
// ============================================================================
//  Module      : ovi_sb_pkg
//  Description : Shared widths, entry/FSM state types and a data-fit helper
//                for the OVI scoreboard-ID scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ovi_sb_pkg;

  localparam int OVI_INSTR_WIDTH      = 32;
  localparam int OVI_SBID_WIDTH       = 5;
  localparam int OVI_SCALAROPND_WIDTH = 64;
  localparam int OVI_DATA_WIDTH       = 32;

  // Number of result bits that survive the scalar-operand to core-data fit
  localparam int FIT_W = (OVI_DATA_WIDTH < OVI_SCALAROPND_WIDTH) ?
                         OVI_DATA_WIDTH : OVI_SCALAROPND_WIDTH;

  typedef logic [OVI_SBID_WIDTH-1:0] sb_id_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ISSUED = 2'd1,
    SENIOR = 2'd2
  } ent_state_e;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } fsm_e;

  // Zero-extend or truncate a VPU scalar result to the core data width
  function automatic logic [OVI_DATA_WIDTH-1:0] fit_data(
    input logic [OVI_SCALAROPND_WIDTH-1:0] v
  );
    logic [OVI_DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < FIT_W; i++) r[i] = v[i];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ovi_sb_order_fifo.sv
// ============================================================================
//  Module      : ovi_sb_order_fifo
//  Description : Circular FIFO of sb_ids recording program order of issued
//                but not yet dispatched instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ovi_sb_order_fifo
  import ovi_sb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push_i,
  input  sb_id_t           push_id_i,
  input  logic             pop_i,
  output sb_id_t           head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  sb_id_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer, count and storage update; pushes and pops may share a cycle
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_id_i;
        wr_q        <= bump(wr_q);
      end
      if (pop_i) rd_q <= bump(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ovi_sb_sched.sv
// ============================================================================
//  Module      : ovi_sb_sched
//  Description : Scoreboard-ID scheduler between the core and the OVI vector
//                unit: sb_id allocation, credit-gated issue, in-order
//                commit/kill dispatch and out-of-order completion retire.
//                Optional macro OVI_SB_PERF_EN adds perf_issued, perf_killed
//                and perf_stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ovi_sb_sched
  import ovi_sb_pkg::*;
#(
  parameter int NUM_SB        = 8,
  parameter int ISSUE_CREDITS = 4
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            core_issue_valid,
  input  logic [OVI_INSTR_WIDTH-1:0]      core_issue_instr,
  output logic                            core_issue_ready,
  input  logic                            core_commit,
  input  logic                            core_kill,
  output logic                            vpu_issue_valid,
  output logic [OVI_INSTR_WIDTH-1:0]      vpu_issue_instr,
  output logic [OVI_SBID_WIDTH-1:0]       vpu_issue_sb_id,
  input  logic                            vpu_issue_credit,
  output logic                            vpu_dispatch_valid,
  output logic [OVI_SBID_WIDTH-1:0]       vpu_dispatch_sb_id,
  output logic                            vpu_dispatch_next_senior,
  output logic                            vpu_dispatch_kill,
  input  logic                            vpu_completed_valid,
  input  logic [OVI_SBID_WIDTH-1:0]       vpu_completed_sb_id,
  input  logic [OVI_SCALAROPND_WIDTH-1:0] vpu_completed_dest_reg,
  input  logic                            vpu_completed_illegal,
  output logic                            core_completed_valid,
  output logic [OVI_DATA_WIDTH-1:0]       core_completed_data,
  output logic                            core_completed_illegal,
  output logic                            busy,
  output logic                            err
`ifdef OVI_SB_PERF_EN
  ,
  output logic [31:0]                     perf_issued,
  output logic [31:0]                     perf_killed,
  output logic [31:0]                     perf_stall
`endif
);

  localparam int              CR_W   = $clog2(ISSUE_CREDITS + 1);
  localparam int              CNT_W  = $clog2(NUM_SB + 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(ISSUE_CREDITS);

  ent_state_e             st_q [NUM_SB];
  ent_state_e             st_d [NUM_SB];
  fsm_e                   fsm_q;
  logic [CR_W-1:0]        cred_q;
  logic [CR_W-1:0]        cred_d;
  logic                   cred_err;

  logic                       iss_valid_q;
  logic [OVI_INSTR_WIDTH-1:0] iss_instr_q;
  sb_id_t                     iss_sb_id_q;
  logic                       dsp_valid_q;
  sb_id_t                     dsp_sb_id_q;
  logic                       dsp_senior_q;
  logic                       dsp_kill_q;
  logic                       cmp_valid_q;
  logic [OVI_DATA_WIDTH-1:0]  cmp_data_q;
  logic                       cmp_illegal_q;
  logic                       err_q;

  sb_id_t           alloc_id;
  logic             free_any;
  logic             any_busy;
  logic             cmp_senior;
  logic             cmp_ok;
  logic             accept;
  logic             commit_pop;
  logic             commit_err;
  logic             kill_pop;
  logic             fifo_pop;
  sb_id_t           fifo_head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  ovi_sb_order_fifo #(.DEPTH(NUM_SB)) u_order (
    .clk       (clk),
    .rst_l     (rst_l),
    .push_i    (accept),
    .push_id_i (alloc_id),
    .pop_i     (fifo_pop),
    .head_o    (fifo_head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Lowest-index free entry, busy flag and completion target lookup
  always_comb begin
    alloc_id   = '0;
    free_any   = 1'b0;
    any_busy   = 1'b0;
    cmp_senior = 1'b0;
    for (int i = NUM_SB - 1; i >= 0; i--) begin
      if (st_q[i] == FREE) begin
        alloc_id = sb_id_t'(i);
        free_any = 1'b1;
      end else begin
        any_busy = 1'b1;
      end
      if (vpu_completed_sb_id == sb_id_t'(i) && st_q[i] == SENIOR) cmp_senior = 1'b1;
    end
  end

  // Reset gates ready so every output reads 0 while rst_l is low
  assign core_issue_ready = rst_l & (fsm_q == RUN) & free_any & (cred_q != '0) & ~core_kill;
  assign accept     = core_issue_valid & core_issue_ready;
  assign commit_pop = (fsm_q == RUN) & core_commit & ~fifo_empty;
  assign commit_err = (fsm_q == RUN) & core_commit & fifo_empty;
  assign kill_pop   = (fsm_q == KILL) & ~fifo_empty;
  assign fifo_pop   = commit_pop | kill_pop;
  assign cmp_ok     = vpu_completed_valid & cmp_senior;

  // Credit bookkeeping; a return beyond the grant saturates and flags err
  always_comb begin
    cred_d   = cred_q;
    cred_err = 1'b0;
    case ({accept, vpu_issue_credit})
      2'b10: cred_d = cred_q - CR_W'(1);
      2'b01: begin
        if (cred_q == CR_MAX) cred_err = 1'b1;
        else                  cred_d   = cred_q + CR_W'(1);
      end
      default: cred_d = cred_q;
    endcase
  end

  // Per-entry next state; issue, dispatch and completion never hit the same entry
  always_comb begin
    st_d = st_q;
    for (int i = 0; i < NUM_SB; i++) begin
      if (accept && alloc_id == sb_id_t'(i)) st_d[i] = ISSUED;
      if (fifo_pop && fifo_head == sb_id_t'(i)) st_d[i] = kill_pop ? FREE : SENIOR;
      if (cmp_ok && vpu_completed_sb_id == sb_id_t'(i)) st_d[i] = FREE;
    end
  end

  // RUN/KILL sequencer with all bus outputs registered
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fsm_q         <= RUN;
      cred_q        <= CR_MAX;
      for (int i = 0; i < NUM_SB; i++) st_q[i] <= FREE;
      iss_valid_q   <= 1'b0;
      iss_instr_q   <= '0;
      iss_sb_id_q   <= '0;
      dsp_valid_q   <= 1'b0;
      dsp_sb_id_q   <= '0;
      dsp_senior_q  <= 1'b0;
      dsp_kill_q    <= 1'b0;
      cmp_valid_q   <= 1'b0;
      cmp_data_q    <= '0;
      cmp_illegal_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (fsm_q)
        RUN:     if (core_kill) fsm_q <= KILL;
        KILL:    if (fifo_empty || fifo_count == CNT_W'(1)) fsm_q <= RUN;
        default: fsm_q <= RUN;
      endcase
      cred_q        <= cred_d;
      st_q          <= st_d;
      iss_valid_q   <= accept;
      iss_instr_q   <= accept ? core_issue_instr : '0;
      iss_sb_id_q   <= accept ? alloc_id : '0;
      dsp_valid_q   <= fifo_pop;
      dsp_sb_id_q   <= fifo_pop ? fifo_head : '0;
      dsp_senior_q  <= commit_pop;
      dsp_kill_q    <= kill_pop;
      cmp_valid_q   <= cmp_ok;
      cmp_data_q    <= cmp_ok ? fit_data(vpu_completed_dest_reg) : '0;
      cmp_illegal_q <= cmp_ok & vpu_completed_illegal;
      err_q         <= err_q | cred_err | commit_err | (vpu_completed_valid & ~cmp_senior);
    end
  end

  assign vpu_issue_valid          = iss_valid_q;
  assign vpu_issue_instr          = iss_instr_q;
  assign vpu_issue_sb_id          = iss_sb_id_q;
  assign vpu_dispatch_valid       = dsp_valid_q;
  assign vpu_dispatch_sb_id       = dsp_sb_id_q;
  assign vpu_dispatch_next_senior = dsp_senior_q;
  assign vpu_dispatch_kill        = dsp_kill_q;
  assign core_completed_valid     = cmp_valid_q;
  assign core_completed_data      = cmp_data_q;
  assign core_completed_illegal   = cmp_illegal_q;
  assign busy                     = any_busy;
  assign err                      = err_q;

`ifdef OVI_SB_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_killed_q;
  logic [31:0] perf_stall_q;

  // Free-running wrapping event counters
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      perf_issued_q <= '0;
      perf_killed_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_q + 32'(accept);
      perf_killed_q <= perf_killed_q + 32'(kill_pop);
      perf_stall_q  <= perf_stall_q + 32'(core_issue_valid & ~core_issue_ready);
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_killed = perf_killed_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

`default_nettype wire
